// File: rtl/ahb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_if
// Signal bundle between the AHB masters/bus fabric and the 3-master arbiter.
//   hbusreq   [2:0] per-master bus request (bit i = master i)
//   hlock     [2:0] per-master locked-transfer request
//   htrans    [1:0] transfer type of the current address phase
//   hburst    [2:0] burst type of the current address phase
//   hready          transfer done / bus advance
//   hresp     [1:0] slave response
//   hgrant    [2:0] one-hot grant (arbiter output)
//   hmaster   [1:0] owner of the current address phase (arbiter output)
//   hmastlock       current address phase is locked (arbiter output)
// Modports: master = bus/requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface ahb_arbiter_if;
    logic [2:0] hbusreq;
    logic [2:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [1:0] hresp;
    logic [2:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready, hresp,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready, hresp,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
// Three-master AHB arbiter: round-robin grant with default master, fixed-length
// burst hold, INCR hold and locked-transfer hold. All outputs registered and
// advanced only on hready=1 edges.
// Ports:
//   hclk    bus clock
//   hreset  synchronous active-high reset
//   bus     ahb_arbiter_if.slave (requests, transfer info in; grant info out)
// Parameter:
//   DEF_MST default master index, granted when nobody requests
// ---------------------------------------------------------------------------
module ahb_arbiter #(
    parameter logic [1:0] DEF_MST = 2'd0
) (
    input  logic         hclk,
    input  logic         hreset,
    ahb_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_BURST,
        ST_LOCKED
    } state_e;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [2:0] BURST_INCR = 3'b001;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] rr_q, rr_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] mst_q, mst_d;
    logic       mlock_q, mlock_d;

    logic [1:0] owner;
    logic [1:0] rr_pick;
    logic [1:0] cand;
    logic       found;
    logic [3:0] burst_last;
    logic       rearb;

    // Index of the currently granted master (grant is always one-hot).
    always_comb begin
        owner = DEF_MST;
        case (grant_q)
            3'b001:  owner = 2'd0;
            3'b010:  owner = 2'd1;
            3'b100:  owner = 2'd2;
            default: owner = DEF_MST;
        endcase
    end

    // Round-robin search starting after the last granted master.
    always_comb begin
        rr_pick = DEF_MST;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= 3; k++) begin
            cand = 2'((32'(rr_q) + k) % 3);
            if (!found && bus.hbusreq[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    end

    // Counter load value (beats - 1) for fixed-length bursts.
    always_comb begin
        burst_last = '0;
        case (bus.hburst[2:1])
            2'b01:   burst_last = 4'd3;
            2'b10:   burst_last = 4'd7;
            2'b11:   burst_last = 4'd15;
            default: burst_last = '0;
        endcase
    end

    // Next-state logic. Entering BURST or LOCKED keeps the current grant;
    // a grant change happens only while idling in ARB or on an exit edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        mst_d   = mst_q;
        mlock_d = mlock_q;
        rearb   = 1'b0;

        if (bus.hready) begin
            mst_d   = owner;
            mlock_d = bus.hlock[owner];

            case (state_q)
                ST_ARB: begin
                    if (bus.hlock[owner]) begin
                        state_d = ST_LOCKED;
                    end else if (bus.htrans == TR_NONSEQ && bus.hburst[2:1] != 2'b00) begin
                        state_d = ST_BURST;
                        cnt_d   = burst_last;
                    end else if (bus.hburst == BURST_INCR && bus.hbusreq[owner] &&
                                 (bus.htrans == TR_SEQ || bus.htrans == TR_BUSY)) begin
                        rearb = 1'b0;
                    end else begin
                        rearb = 1'b1;
                    end
                end
                ST_BURST: begin
                    if (bus.hlock[owner]) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                    end else if (bus.hresp != RESP_OKAY ||
                                 bus.htrans == TR_IDLE || bus.htrans == TR_NONSEQ) begin
                        state_d = ST_ARB;
                        cnt_d   = '0;
                        rearb   = 1'b1;
                    end else if (bus.htrans == TR_SEQ) begin
                        if (cnt_q <= 4'd1) begin
                            state_d = ST_ARB;
                            cnt_d   = '0;
                            rearb   = 1'b1;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!bus.hlock[owner]) begin
                        state_d = ST_ARB;
                        rearb   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                end
            endcase

            if (rearb) begin
                grant_d = 3'b001 << rr_pick;
                rr_d    = rr_pick;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= ST_ARB;
            cnt_q   <= '0;
            rr_q    <= DEF_MST;
            grant_q <= 3'b001 << DEF_MST;
            mst_q   <= DEF_MST;
            mlock_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            mst_q   <= mst_d;
            mlock_q <= mlock_d;
        end
    end

    assign bus.hgrant    = grant_q;
    assign bus.hmaster   = mst_q;
    assign bus.hmastlock = mlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter
// Directed scenarios followed by randomized traffic, every edge compared with
// a behavioural model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter;

    localparam logic [1:0] DEF = 2'd0;

    logic clk = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    int m_grant;
    int m_master;
    int m_last;
    bit m_mlock;
    bit m_locked;
    int m_beats;   // SEQ beats still owed by the current fixed burst

    ahb_arbiter_if bus_if();

    ahb_arbiter #(.DEF_MST(DEF)) dut (
        .hclk   (clk),
        .hreset (rst),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] req, input logic [2:0] lock,
                         input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                         input logic [1:0] resp);
        rst            = r;
        bus_if.hbusreq = req;
        bus_if.hlock   = lock;
        bus_if.htrans  = tr;
        bus_if.hburst  = bu;
        bus_if.hready  = rdy;
        bus_if.hresp   = resp;
    endtask

    task automatic model_step();
        int  own;
        int  tr;
        int  hb;
        int  pick;
        bit  lk;
        bit  free;
        if (rst === 1'b1) begin
            m_grant  = int'(DEF);
            m_master = int'(DEF);
            m_last   = int'(DEF);
            m_mlock  = 1'b0;
            m_locked = 1'b0;
            m_beats  = 0;
            return;
        end
        if (bus_if.hready !== 1'b1) return;
        own  = m_grant;
        lk   = bus_if.hlock[own];
        tr   = int'(bus_if.htrans);
        hb   = int'(bus_if.hburst);
        free = 1'b0;
        if (m_locked) begin
            if (!lk) begin
                m_locked = 1'b0;
                free     = 1'b1;
            end
        end else if (lk) begin
            m_locked = 1'b1;
            m_beats  = 0;
        end else if (m_beats > 0) begin
            if (bus_if.hresp != 2'b00 || tr == 0 || tr == 2) begin
                m_beats = 0;
                free    = 1'b1;
            end else if (tr == 3) begin
                m_beats--;
                if (m_beats == 0) free = 1'b1;
            end
        end else begin
            if (tr == 2 && hb >= 2)
                m_beats = (4 << ((hb - 2) / 2)) - 1;
            else if (!(hb == 1 && bus_if.hbusreq[own] && (tr == 3 || tr == 1)))
                free = 1'b1;
        end
        if (free) begin
            pick = int'(DEF);
            for (int k = 3; k >= 1; k--)
                if (bus_if.hbusreq[(m_last + k) % 3]) pick = (m_last + k) % 3;
            m_grant = pick;
            m_last  = pick;
        end
        m_master = own;
        m_mlock  = lk;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model_grant",  32'(bus_if.hgrant),    32'd1 << m_grant);
        chk("model_master", 32'(bus_if.hmaster),   32'(m_master));
        chk("model_mlock",  32'(bus_if.hmastlock), 32'(m_mlock));
    endtask

    initial begin
        // Reset with everybody requesting.
        drive(1'b1, 3'b111, 3'b000, 2'b00, 3'b000, 1'b1, 2'b00);
        cycle();
        cycle();
        chk("rst_grant",  32'(bus_if.hgrant),    32'h1);
        chk("rst_master", 32'(bus_if.hmaster),   32'h0);
        chk("rst_mlock",  32'(bus_if.hmastlock), 32'h0);
        drive(1'b0, 3'b111, 3'b000, 2'b00, 3'b000, 1'b1, 2'b00);
        cycle();
        chk("rst_first_arb", 32'(bus_if.hgrant), 32'h2);

        // Round robin between masters 1 and 2, starting from master 0.
        drive(1'b1, 3'b110, 3'b000, 2'b00, 3'b000, 1'b1, 2'b00);
        cycle();
        drive(1'b0, 3'b110, 3'b000, 2'b00, 3'b000, 1'b1, 2'b00);
        cycle();
        chk("rr_g1", 32'(bus_if.hgrant), 32'h2);
        chk("rr_m1", 32'(bus_if.hmaster), 32'h0);
        cycle();
        chk("rr_g2", 32'(bus_if.hgrant), 32'h4);
        chk("rr_m2", 32'(bus_if.hmaster), 32'h1);
        cycle();
        chk("rr_g3", 32'(bus_if.hgrant), 32'h2);
        chk("rr_m3", 32'(bus_if.hmaster), 32'h2);

        // INCR4 by master 1 while master 2 waits.
        drive(1'b0, 3'b110, 3'b000, 2'b10, 3'b011, 1'b1, 2'b00);
        cycle();
        chk("burst_nonseq", 32'(bus_if.hgrant), 32'h2);
        drive(1'b0, 3'b110, 3'b000, 2'b11, 3'b011, 1'b1, 2'b00);
        cycle();
        chk("burst_seq1", 32'(bus_if.hgrant), 32'h2);
        cycle();
        chk("burst_seq2", 32'(bus_if.hgrant), 32'h2);
        cycle();
        chk("burst_seq3", 32'(bus_if.hgrant), 32'h4);

        // Wait states with toggling requests.
        drive(1'b0, 3'b001, 3'b000, 2'b00, 3'b000, 1'b0, 2'b00);
        cycle();
        bus_if.hbusreq = 3'b010;
        cycle();
        bus_if.hbusreq = 3'b111;
        cycle();
        chk("wait_grant",  32'(bus_if.hgrant),    32'h4);
        chk("wait_master", 32'(bus_if.hmaster),   32'h1);
        chk("wait_mlock",  32'(bus_if.hmastlock), 32'h0);
        drive(1'b0, 3'b001, 3'b000, 2'b00, 3'b000, 1'b1, 2'b00);
        cycle();
        chk("wait_resume", 32'(bus_if.hgrant), 32'h1);

        // Locked sequence by master 2.
        drive(1'b0, 3'b111, 3'b000, 2'b00, 3'b000, 1'b1, 2'b00);
        cycle();
        cycle();
        chk("lock_pre", 32'(bus_if.hgrant), 32'h4);
        bus_if.hlock = 3'b100;
        cycle();
        cycle();
        chk("lock_grant",  32'(bus_if.hgrant),    32'h4);
        chk("lock_master", 32'(bus_if.hmaster),   32'h2);
        chk("lock_mlock",  32'(bus_if.hmastlock), 32'h1);
        bus_if.hlock = 3'b000;
        cycle();
        chk("lock_exit", 32'(bus_if.hgrant), 32'h1);

        // ERROR on second beat of master 0's INCR8.
        drive(1'b0, 3'b011, 3'b000, 2'b10, 3'b101, 1'b1, 2'b00);
        cycle();
        chk("err_start", 32'(bus_if.hgrant), 32'h1);
        drive(1'b0, 3'b011, 3'b000, 2'b11, 3'b101, 1'b1, 2'b01);
        cycle();
        chk("err_regrant", 32'(bus_if.hgrant), 32'h2);
        drive(1'b0, 3'b011, 3'b000, 2'b11, 3'b000, 1'b1, 2'b00);
        cycle();
        chk("err_in_arb", 32'(bus_if.hgrant), 32'h1);

        // Reset in the middle of an INCR16 leaves no hold behind.
        drive(1'b0, 3'b111, 3'b000, 2'b10, 3'b111, 1'b1, 2'b00);
        cycle();
        drive(1'b1, 3'b111, 3'b000, 2'b11, 3'b111, 1'b1, 2'b00);
        cycle();
        drive(1'b0, 3'b110, 3'b000, 2'b11, 3'b000, 1'b1, 2'b00);
        cycle();
        chk("rst_midburst", 32'(bus_if.hgrant), 32'h2);

        // Nobody requesting selects the default master.
        drive(1'b0, 3'b000, 3'b000, 2'b00, 3'b000, 1'b1, 2'b00);
        cycle();
        chk("default_mst", 32'(bus_if.hgrant), 32'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 49) == 0),
                  3'($urandom),
                  ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000,
                  2'($urandom),
                  3'($urandom),
                  1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00);
            cycle();
            chk("onehot", 32'($countones(bus_if.hgrant)), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter DEF_MST, default 2'd0: default master index (0..2), granted when no master requests.
REQ-002 hclk  input  1  bus clock; all state changes on rising edge.
REQ-003 hreset  input  1  reset, synchronous, active-high.
REQ-004 hbusreq  input  3  per-master bus request; bit i = master i.
REQ-005 hlock  input  3  per-master locked-transfer request.
REQ-006 htrans  input  2  transfer type of the current address phase (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 hburst  input  3  burst type of the current address phase.
REQ-008 hready  input  1  transfer done / bus advance.
REQ-009 hresp  input  2  slave response (00 OKAY, 01 ERROR, 10 SPLIT, 11 RETRY).
REQ-010 hgrant  output  3  one-hot grant; always exactly one bit set.
REQ-011 hmaster  output  2  index of the master owning the current address phase.
REQ-012 hmastlock  output  1  current address phase is locked.

Function
REQ-013 hgrant, hmaster and hmastlock SHALL be registered; all updates occur only on a hclk edge where hready=1, except reset.
REQ-014 hmaster SHALL load the index of the hgrant bit, and hmastlock SHALL load hlock[that index], on each hclk edge with hready=1.
REQ-015 Arbitration SHALL be round-robin: search starts at the master after the last granted index and wraps 2->0; the first master with hbusreq set wins.
REQ-016 If no hbusreq bit is set, hgrant SHALL select DEF_MST.
REQ-017 The FSM SHALL have three states: ARB, BURST and LOCKED; re-arbitration SHALL be allowed only in ARB, or on the exit edge out of BURST or LOCKED.
REQ-018 ARB->BURST: on hready=1 with htrans=NONSEQ and hburst in {010,011} (4 beats), {100,101} (8 beats) or {110,111} (16 beats).
  - A 4-bit beat counter SHALL load len-1 on this edge.
REQ-019 In BURST, each edge with hready=1 and htrans=SEQ SHALL decrement the counter.
  - When the counter=1 on that edge, the FSM SHALL re-arbitrate and return to ARB.
  - BUSY SHALL hold the counter.
REQ-020 hburst=001 (INCR): the grant SHALL be held while the owning master keeps hbusreq set and htrans is SEQ or BUSY.
REQ-021 hburst=000 (SINGLE): no hold; the FSM stays in ARB.
REQ-022 Early termination: in BURST, htrans=IDLE or NONSEQ with hready=1, or hresp=ERROR/RETRY/SPLIT, SHALL force the FSM to ARB and allow re-arbitration on that same edge.
REQ-023 ARB->LOCKED: when the granted master has hlock set on an edge with hready=1.
  - In LOCKED, the grant SHALL stay frozen regardless of other requests.
  - The FSM SHALL exit to ARB on the first hready=1 edge with the owner's hlock=0.
  - LOCKED SHALL take precedence over BURST.
REQ-024 While hready=0, the FSM, counter, round-robin pointer and all outputs SHALL hold their values.
REQ-025 A request deasserted while its master is granted SHALL NOT cause a regrant until the next permitted arbitration edge.

Reset
REQ-026 On an edge with hreset=1, the block SHALL set:
  - hgrant to the one-hot encoding of DEF_MST, hmaster to DEF_MST, hmastlock to 0;
  - the FSM to ARB, the counter to 0 and the round-robin pointer to DEF_MST.
  hreset SHALL override hready.
REQ-027 Reset mid-burst or mid-lock SHALL abandon the burst or lock with no residual hold on the next cycle.

Verification
REQ-028 Reset: hreset=1 for 2 cycles with hbusreq=111 -> hgrant=001, hmaster=0, hmastlock=0; the first hready=1 edge after release grants master 1.
REQ-029 Round-robin: hbusreq=110, hready=1 held, starting from master 0 -> hgrant sequence 010, 100, 010, with hmaster lagging hgrant by one hready edge.
REQ-030 Burst hold: master 1 issues INCR4 (NONSEQ plus 3 SEQ, hready=1) while hbusreq[2]=1 -> hgrant=010 until the edge accepting the 3rd SEQ, then 100.
REQ-031 Wait states: hready=0 for 3 cycles while hbusreq toggles -> hgrant, hmaster and hmastlock unchanged; arbitration resumes on the first hready=1 edge.
REQ-032 Lock: master 2 asserts hlock=1 with hbusreq=111 -> hgrant=100 held, and hmastlock=1 together with hmaster=2; master 2 drops hlock -> next hready edge grants master 0.
REQ-033 Error: hresp=01 with hready=1 during the 2nd beat of master 0's INCR8 while master 1 requests -> hgrant=010 on that edge, and the FSM is in ARB.
